// File: rtl/rf_write_sched.sv
// rf_write_sched: write-port scheduler for a register bank of dff_en gated-clock words.
// Arbitrates NREQ requesters onto one write port; word enables are retimed to the
// falling clock edge so every word gate sees a full, glitch-free clk-high phase.
// Optional feature: define RFWR_RR_EN for round-robin arbitration (fixed priority otherwise).
module rf_write_sched #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned NWORDS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        gnt,
    output logic [NWORDS-1:0]      word_en,
    output logic [DATA_W-1:0]      wr_data,
    output logic                   addr_err,
    output logic                   busy
);
    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic [NREQ-1:0]   gnt_d;
    logic              addr_err_d;
    logic              busy_d;
    logic [NREQ-1:0]   cand_c;
    logic              found_c;
    logic [IDX_W-1:0]  pick_c;
    logic [NWORDS-1:0] word_en_c;
    logic [ADDR_W-1:0] addr_a [NREQ];
    logic [DATA_W-1:0] data_a [NREQ];
`ifdef RFWR_RR_EN
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
`endif

    // Split the flat request buses into per-requester fields
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_a[g] = req_addr[g*ADDR_W +: ADDR_W];
        assign data_a[g] = req_data[g*DATA_W +: DATA_W];
    end

    // Arbiter: the winner of the previous decision is masked for the decision ending ACK
    always_comb begin
        int unsigned idx;
        idx     = 0;
        cand_c  = req;
        found_c = 1'b0;
        pick_c  = '0;
        if (state_q == S_ACK) begin
            cand_c[win_q] = 1'b0;
        end
        for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef RFWR_RR_EN
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
`else
            idx = k;
`endif
            if (!found_c && cand_c[IDX_W'(idx)]) begin
                found_c = 1'b1;
                pick_c  = IDX_W'(idx);
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        wa_d       = wa_q;
        wd_d       = wr_data;
        win_d      = win_q;
        gnt_d      = '0;
        addr_err_d = 1'b0;
        busy_d     = 1'b0;
`ifdef RFWR_RR_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        case (state_q)
            S_IDLE, S_ACK: begin
                if (found_c) begin
                    state_d = S_WR;
                    wa_d    = addr_a[pick_c];
                    wd_d    = data_a[pick_c];
                    win_d   = pick_c;
                    busy_d  = 1'b1;
`ifdef RFWR_RR_EN
                    rr_ptr_d = (32'(pick_c) == NREQ - 1) ? '0 : pick_c + 1'b1;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR: begin
                state_d       = S_ACK;
                gnt_d[win_q]  = 1'b1;
                addr_err_d    = (32'(wa_q) >= NWORDS);
                busy_d        = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wa_q     <= '0;
            wr_data  <= '0;
            win_q    <= '0;
            gnt      <= '0;
            addr_err <= 1'b0;
            busy     <= 1'b0;
`ifdef RFWR_RR_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wa_q     <= wa_d;
            wr_data  <= wd_d;
            win_q    <= win_d;
            gnt      <= gnt_d;
            addr_err <= addr_err_d;
            busy     <= busy_d;
`ifdef RFWR_RR_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    // One-hot word enable decoded from registered state; out-of-range addresses enable nothing
    always_comb begin
        word_en_c = '0;
        for (int unsigned i = 0; i < NWORDS; i++) begin
            word_en_c[i] = (state_q == S_WR) && (32'(wa_q) == i);
        end
    end

    // Retime enables onto the falling edge so they never move while clk is high
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_en <= '0;
        end else begin
            word_en <= word_en_c;
        end
    end

endmodule
